commit_trace_checker: RTL and testbench

COMMIT_TRACE_CHECKER -- requirements
Module: commit_trace_checker

---
 rtl/commit_trace_checker_pkg.sv | 29 ++
 rtl/commit_fifo_2w1r.sv | 54 +++++
 rtl/commit_trace_checker.sv | 177 +++++++++++++++++
 tb/tb_commit_trace_checker.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/commit_trace_checker_pkg.sv
// Shared types for the commit trace checker: commit entry, checker state, error codes.
// Latency: n/a (types and helpers only).
// Backpressure: n/a.
package commit_trace_checker_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  waddr;
        logic [31:0] wdata;
    } commit_entry_t;

    typedef enum logic [1:0] {
        ST_CHECK = 2'd0,
        ST_ERROR = 2'd1,
        ST_DONE  = 2'd2
    } chk_state_e;

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_MISMATCH = 2'b01;
    localparam logic [1:0] ERR_OVERFLOW = 2'b10;
    localparam logic [1:0] ERR_EXTRA    = 2'b11;

    // A register-file write only reaches the trace if it is architecturally visible.
    function automatic logic commit_qualifies(input logic vld, input logic we,
                                              input logic [4:0] waddr);
        return vld & we & (waddr != 5'd0);
    endfunction

endpackage

// File: rtl/commit_fifo_2w1r.sv
// Commit buffer: up to two writes (port 1 ordered before port 2) and one read per cycle.
// Latency: written entry visible at head_o the cycle after the write; head_o is combinational.
// Backpressure: none internally; the caller must never push past DEPTH entries.
// Ports: clk, rst_n (sync, active-low), push1_i/push1_dat_i, push2_i/push2_dat_i, pop_i,
//        head_o (oldest entry), count_o (occupancy, 0..DEPTH).
module commit_fifo_2w1r
    import commit_trace_checker_pkg::*;
#(
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push1_i,
    input  commit_entry_t push1_dat_i,
    input  logic          push2_i,
    input  commit_entry_t push2_dat_i,
    input  logic          pop_i,
    output commit_entry_t head_o,
    output logic [CW-1:0] count_o
);

    commit_entry_t   mem_q [DEPTH];
    logic [AW-1:0]   wptr_q;
    logic [AW-1:0]   rptr_q;
    logic [CW-1:0]   count_q;
    logic [AW-1:0]   wptr2;

    // Port 2 lands in the slot after port 1 only when port 1 also writes.
    // DEPTH is a power of two, so pointer arithmetic wraps on its own.
    assign wptr2 = wptr_q + AW'(push1_i);

    always_ff @(posedge clk) begin
        if (push1_i) mem_q[wptr_q] <= push1_dat_i;
        if (push2_i) mem_q[wptr2]  <= push2_dat_i;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_q + AW'(push1_i) + AW'(push2_i);
            rptr_q  <= rptr_q + AW'(pop_i);
            count_q <= count_q + CW'(push1_i) + CW'(push2_i) - CW'(pop_i);
        end
    end

    assign head_o  = mem_q[rptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/commit_trace_checker.sv
// Compares dual-lane writeback commits against a golden trace, latching the first error.
// Latency: one cycle from a golden pop (or offending commit) to error_o / err_* outputs.
// Backpressure: gold_ready_o high only in CHECK with a buffered commit; lanes are never stalled.
// Ports: clk, rst_n (sync, active-low); l1_*/l2_* writeback lanes (lane 1 older);
//        gold_* golden-trace handshake plus gold_end_i; error_o/err_code_o/err_pc_o/
//        err_exp_wdata_o/err_got_wdata_o error report; done_o trace completed.
//        Macro COMMIT_CHECK_PERF_CNT_EN adds commit_cnt_o and max_occ_o.
module commit_trace_checker
    import commit_trace_checker_pkg::*;
#(
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        l1_valid_i,
    input  logic        l1_we_i,
    input  logic [31:0] l1_pc_i,
    input  logic [4:0]  l1_waddr_i,
    input  logic [31:0] l1_wdata_i,
    input  logic        l2_valid_i,
    input  logic        l2_we_i,
    input  logic [31:0] l2_pc_i,
    input  logic [4:0]  l2_waddr_i,
    input  logic [31:0] l2_wdata_i,
    input  logic        gold_valid_i,
    output logic        gold_ready_o,
    input  logic [31:0] gold_pc_i,
    input  logic [4:0]  gold_waddr_i,
    input  logic [31:0] gold_wdata_i,
    input  logic        gold_end_i,
    output logic        error_o,
    output logic [1:0]  err_code_o,
    output logic [31:0] err_pc_o,
    output logic [31:0] err_exp_wdata_o,
    output logic [31:0] err_got_wdata_o,
    output logic        done_o
`ifdef COMMIT_CHECK_PERF_CNT_EN
    ,
    output logic [31:0]                  commit_cnt_o,
    output logic [$clog2(FIFO_DEPTH):0]  max_occ_o
`endif
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    chk_state_e    state_q, state_d;
    logic [1:0]    err_code_q, err_code_d;
    logic [31:0]   err_pc_q, err_pc_d;
    logic [31:0]   err_exp_q, err_exp_d;
    logic [31:0]   err_got_q, err_got_d;

    commit_entry_t l1_ent, l2_ent, gold_ent, head;
    logic          q1, q2, pop, push1_en, push2_en;
    logic [CW-1:0] fifo_count;
    int            n_push, occ_after_pop, free_slots;

    assign l1_ent   = '{pc: l1_pc_i, waddr: l1_waddr_i, wdata: l1_wdata_i};
    assign l2_ent   = '{pc: l2_pc_i, waddr: l2_waddr_i, wdata: l2_wdata_i};
    assign gold_ent = '{pc: gold_pc_i, waddr: gold_waddr_i, wdata: gold_wdata_i};

    assign q1 = commit_qualifies(l1_valid_i, l1_we_i, l1_waddr_i);
    assign q2 = commit_qualifies(l2_valid_i, l2_we_i, l2_waddr_i);

    assign gold_ready_o = (state_q == ST_CHECK) && (fifo_count != '0);
    assign pop          = gold_valid_i & gold_ready_o;

    commit_fifo_2w1r #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push1_i     (push1_en),
        .push1_dat_i (l1_ent),
        .push2_i     (push2_en),
        .push2_dat_i (l2_ent),
        .pop_i       (pop),
        .head_o      (head),
        .count_o     (fifo_count)
    );

    always_comb begin
        state_d       = state_q;
        err_code_d    = err_code_q;
        err_pc_d      = err_pc_q;
        err_exp_d     = err_exp_q;
        err_got_d     = err_got_q;
        push1_en      = 1'b0;
        push2_en      = 1'b0;
        n_push        = int'(q1) + int'(q2);
        occ_after_pop = int'(fifo_count) - int'(pop);
        free_slots    = FIFO_DEPTH - occ_after_pop;

        case (state_q)
            ST_CHECK: begin
                // Excess commits beyond the free slots are dropped; lane 1 claims space first.
                push1_en = q1 && (free_slots != 0);
                push2_en = q2 && (free_slots > int'(q1));
                if (pop && (head != gold_ent)) begin
                    state_d    = ST_ERROR;
                    err_code_d = ERR_MISMATCH;
                    err_pc_d   = head.pc;
                    err_exp_d  = gold_wdata_i;
                    err_got_d  = head.wdata;
                end else if (occ_after_pop + n_push > FIFO_DEPTH) begin
                    // The first dropped commit is lane 1 only if there was no room at all.
                    state_d    = ST_ERROR;
                    err_code_d = ERR_OVERFLOW;
                    err_pc_d   = (q1 && free_slots == 0) ? l1_pc_i    : l2_pc_i;
                    err_exp_d  = 32'd0;
                    err_got_d  = (q1 && free_slots == 0) ? l1_wdata_i : l2_wdata_i;
                end else if (gold_end_i) begin
                    if (fifo_count != '0) begin
                        // Trace ended with commits still unmatched: report the oldest.
                        state_d    = ST_ERROR;
                        err_code_d = ERR_EXTRA;
                        err_pc_d   = head.pc;
                        err_exp_d  = 32'd0;
                        err_got_d  = head.wdata;
                    end else if (n_push == 0) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (q1 || q2) begin
                    state_d    = ST_ERROR;
                    err_code_d = ERR_EXTRA;
                    err_pc_d   = q1 ? l1_pc_i    : l2_pc_i;
                    err_exp_d  = 32'd0;
                    err_got_d  = q1 ? l1_wdata_i : l2_wdata_i;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_CHECK;
            err_code_q <= ERR_NONE;
            err_pc_q   <= '0;
            err_exp_q  <= '0;
            err_got_q  <= '0;
        end else begin
            state_q    <= state_d;
            err_code_q <= err_code_d;
            err_pc_q   <= err_pc_d;
            err_exp_q  <= err_exp_d;
            err_got_q  <= err_got_d;
        end
    end

    assign error_o         = (state_q == ST_ERROR);
    assign done_o          = (state_q == ST_DONE);
    assign err_code_o      = err_code_q;
    assign err_pc_o        = err_pc_q;
    assign err_exp_wdata_o = err_exp_q;
    assign err_got_wdata_o = err_got_q;

`ifdef COMMIT_CHECK_PERF_CNT_EN
    logic [31:0]   commit_cnt_q;
    logic [CW-1:0] max_occ_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            commit_cnt_q <= '0;
            max_occ_q    <= '0;
        end else begin
            if (pop && (commit_cnt_q != '1)) commit_cnt_q <= commit_cnt_q + 32'd1;
            // Occupancy never exceeds FIFO_DEPTH, so the peak saturates naturally.
            if (fifo_count > max_occ_q) max_occ_q <= fifo_count;
        end
    end

    assign commit_cnt_o = commit_cnt_q;
    assign max_occ_o    = max_occ_q;
`endif

endmodule

// File: tb/tb_commit_trace_checker.sv
// Scoreboard bench for commit_trace_checker: directed scenarios plus randomized episodes.
// Latency: expected outputs for each clock edge are queued before the edge, compared after it.
// Backpressure: golden entries are offered only from the bench's own commit queue model.
module tb_commit_trace_checker;

    localparam int DEPTH = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        l1_valid, l1_we, l2_valid, l2_we;
    logic [31:0] l1_pc, l1_wdata, l2_pc, l2_wdata;
    logic [4:0]  l1_waddr, l2_waddr;
    logic        gold_valid, gold_end;
    logic [31:0] gold_pc, gold_wdata;
    logic [4:0]  gold_waddr;
    logic        gold_ready, error, done;
    logic [1:0]  err_code;
    logic [31:0] err_pc, err_exp, err_got;

    commit_trace_checker #(.FIFO_DEPTH(DEPTH)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .l1_valid_i      (l1_valid),
        .l1_we_i         (l1_we),
        .l1_pc_i         (l1_pc),
        .l1_waddr_i      (l1_waddr),
        .l1_wdata_i      (l1_wdata),
        .l2_valid_i      (l2_valid),
        .l2_we_i         (l2_we),
        .l2_pc_i         (l2_pc),
        .l2_waddr_i      (l2_waddr),
        .l2_wdata_i      (l2_wdata),
        .gold_valid_i    (gold_valid),
        .gold_ready_o    (gold_ready),
        .gold_pc_i       (gold_pc),
        .gold_waddr_i    (gold_waddr),
        .gold_wdata_i    (gold_wdata),
        .gold_end_i      (gold_end),
        .error_o         (error),
        .err_code_o      (err_code),
        .err_pc_o        (err_pc),
        .err_exp_wdata_o (err_exp),
        .err_got_wdata_o (err_got),
        .done_o          (done)
    );

    typedef struct {
        logic [31:0] pc;
        logic [4:0]  wa;
        logic [31:0] wd;
    } ent_t;

    typedef struct {
        logic        rdy;
        logic        err;
        logic        dn;
        logic [1:0]  code;
        logic [31:0] pc;
        logic [31:0] exp;
        logic [31:0] got;
    } obs_t;

    // Reference model: commit queue plus a checker mode (0 checking, 1 error, 2 done).
    ent_t        model_q[$];
    obs_t        exp_q[$];
    int          m_mode;
    logic [1:0]  m_code;
    logic [31:0] m_pc, m_exp, m_got;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, got, want, $time);
        end
    endtask

    task automatic set_err(input logic [1:0] c, input logic [31:0] pc,
                           input logic [31:0] ex, input logic [31:0] gt);
        m_mode = 1;
        m_code = c;
        m_pc   = pc;
        m_exp  = ex;
        m_got  = gt;
    endtask

    // Predict this cycle's effect, queue the expected post-edge outputs, then clock.
    task automatic step();
        ent_t p[$];
        ent_t e;
        obs_t o;
        int   sz, avail;
        bit   pop, mism;
        if (!rst_n) begin
            model_q.delete();
            m_mode = 0; m_code = 2'b00; m_pc = 0; m_exp = 0; m_got = 0;
        end else begin
            if (l1_valid && l1_we && l1_waddr != 5'd0) begin
                e.pc = l1_pc; e.wa = l1_waddr; e.wd = l1_wdata; p.push_back(e);
            end
            if (l2_valid && l2_we && l2_waddr != 5'd0) begin
                e.pc = l2_pc; e.wa = l2_waddr; e.wd = l2_wdata; p.push_back(e);
            end
            sz  = model_q.size();
            pop = (m_mode == 0) && (sz > 0) && gold_valid;
            if (m_mode == 0) begin
                avail = DEPTH - (sz - int'(pop));
                mism  = pop && (model_q[0].pc !== gold_pc || model_q[0].wa !== gold_waddr ||
                                model_q[0].wd !== gold_wdata);
                if (mism)                       set_err(2'b01, model_q[0].pc, gold_wdata, model_q[0].wd);
                else if (p.size() > avail)      set_err(2'b10, p[avail].pc, 32'd0, p[avail].wd);
                else if (gold_end && sz > 0)    set_err(2'b11, model_q[0].pc, 32'd0, model_q[0].wd);
                else if (gold_end && p.size() == 0) m_mode = 2;
                if (pop) void'(model_q.pop_front());
                for (int i = 0; i < p.size() && i < avail; i++) model_q.push_back(p[i]);
            end else if (m_mode == 2 && p.size() > 0) begin
                set_err(2'b11, p[0].pc, 32'd0, p[0].wd);
            end
        end
        o.rdy  = (m_mode == 0) && (model_q.size() > 0);
        o.err  = (m_mode == 1);
        o.dn   = (m_mode == 2);
        o.code = m_code;
        o.pc   = m_pc;
        o.exp  = m_exp;
        o.got  = m_got;
        exp_q.push_back(o);
        @(posedge clk);
        #1;
    endtask

    // Monitor: outputs are stable mid-cycle; compare against the oldest queued prediction.
    initial begin
        forever begin
            obs_t o;
            @(negedge clk);
            if (exp_q.size() > 0) begin
                o = exp_q.pop_front();
                chk("sb_gold_ready", {31'd0, gold_ready}, {31'd0, o.rdy});
                chk("sb_error",      {31'd0, error},      {31'd0, o.err});
                chk("sb_done",       {31'd0, done},       {31'd0, o.dn});
                chk("sb_err_code",   {30'd0, err_code},   {30'd0, o.code});
                chk("sb_err_pc",     err_pc,  o.pc);
                chk("sb_err_exp",    err_exp, o.exp);
                chk("sb_err_got",    err_got, o.got);
            end
        end
    end

    task automatic idle();
        l1_valid = 0; l1_we = 0; l1_pc = 0; l1_waddr = 0; l1_wdata = 0;
        l2_valid = 0; l2_we = 0; l2_pc = 0; l2_waddr = 0; l2_wdata = 0;
        gold_valid = 0; gold_end = 0; gold_pc = 0; gold_waddr = 0; gold_wdata = 0;
    endtask

    task automatic lane1(input logic [31:0] pc, input logic [4:0] wa, input logic [31:0] wd);
        l1_valid = 1; l1_we = 1; l1_pc = pc; l1_waddr = wa; l1_wdata = wd;
    endtask

    task automatic lane2(input logic [31:0] pc, input logic [4:0] wa, input logic [31:0] wd);
        l2_valid = 1; l2_we = 1; l2_pc = pc; l2_waddr = wa; l2_wdata = wd;
    endtask

    task automatic gold(input logic [31:0] pc, input logic [4:0] wa, input logic [31:0] wd);
        gold_valid = 1; gold_pc = pc; gold_waddr = wa; gold_wdata = wd;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 0;
        step();
        rst_n = 1;
    endtask

    function automatic logic [4:0] rnd_waddr();
        if ($urandom_range(0, 3) == 0) return 5'd0;
        return 5'($urandom_range(1, 31));
    endfunction

    task automatic rnd_inputs();
        int k;
        l1_valid = 1'($urandom_range(0, 1));
        l1_we    = ($urandom_range(0, 3) != 0);
        l1_waddr = rnd_waddr();
        l1_pc    = $urandom;
        l1_wdata = $urandom;
        l2_valid = 1'($urandom_range(0, 1));
        l2_we    = ($urandom_range(0, 3) != 0);
        l2_waddr = rnd_waddr();
        l2_pc    = $urandom;
        l2_wdata = $urandom;
        gold_end = ($urandom_range(0, 59) == 0);
        if (model_q.size() > 0 && $urandom_range(0, 1) == 1) begin
            gold_valid = 1;
            gold_pc    = model_q[0].pc;
            gold_waddr = model_q[0].wa;
            gold_wdata = model_q[0].wd;
            k = $urandom_range(0, 29);
            if (k == 0)      gold_wdata = gold_wdata ^ 32'h1;
            else if (k == 1) gold_waddr = gold_waddr ^ 5'h1;
            else if (k == 2) gold_pc    = gold_pc ^ 32'h4;
        end else begin
            gold_valid = 1'($urandom_range(0, 1));
            gold_pc    = $urandom;
            gold_waddr = 5'($urandom_range(0, 31));
            gold_wdata = $urandom;
        end
    endtask

    initial begin
        idle();
        rst_n = 0;
        step();
        step();
        chk("reset_error",  {31'd0, error},      32'd0);
        chk("reset_done",   {31'd0, done},       32'd0);
        chk("reset_ready",  {31'd0, gold_ready}, 32'd0);
        chk("reset_code",   {30'd0, err_code},   32'd0);
        chk("reset_err_pc", err_pc,              32'd0);
        rst_n = 1;

        // Single lane-1 commit then matching golden entry.
        idle(); lane1(32'h1c00_0000, 5'd4, 32'h5); step();
        chk("single_ready", {31'd0, gold_ready}, 32'd1);
        idle(); gold(32'h1c00_0000, 5'd4, 32'h5); step();
        chk("single_no_err",    {31'd0, error},      32'd0);
        chk("single_drained",   {31'd0, gold_ready}, 32'd0);

        // Dual commit, golden supplies lane 1 then lane 2.
        idle(); lane1(32'h1c00_0004, 5'd1, 32'h1); lane2(32'h1c00_0008, 5'd2, 32'h2); step();
        idle(); gold(32'h1c00_0004, 5'd1, 32'h1); step();
        chk("dual_second_ready", {31'd0, gold_ready}, 32'd1);
        idle(); gold(32'h1c00_0008, 5'd2, 32'h2); step();
        chk("dual_no_err", {31'd0, error},      32'd0);
        chk("dual_empty",  {31'd0, gold_ready}, 32'd0);

        // Writes to r0 or with we=0 are not traced.
        idle(); lane1(32'h1c00_000c, 5'd0, 32'h9); lane2(32'h1c00_000c, 5'd5, 32'h9); l2_we = 0;
        step();
        chk("r0_we0_ready", {31'd0, gold_ready}, 32'd0);

        // Data mismatch at 1c000010.
        idle(); lane1(32'h1c00_0010, 5'd7, 32'h5); step();
        idle(); gold(32'h1c00_0010, 5'd7, 32'h6); step();
        chk("mism_error", {31'd0, error},    32'd1);
        chk("mism_code",  {30'd0, err_code}, 32'd1);
        chk("mism_pc",    err_pc,            32'h1c00_0010);
        chk("mism_exp",   err_exp,           32'h6);
        chk("mism_got",   err_got,           32'h5);
        chk("mism_ready", {31'd0, gold_ready}, 32'd0);

        // Overflow: five dual commits with no golden traffic.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            idle();
            lane1(32'h2000_0000 + 32'(8 * i), 5'(2 * i + 1), 32'(100 + i));
            lane2(32'h2000_0004 + 32'(8 * i), 5'(2 * i + 2), 32'(200 + i));
            step();
            if (i == 3) chk("ovf_not_yet", {31'd0, error}, 32'd0);
        end
        chk("ovf_error", {31'd0, error},    32'd1);
        chk("ovf_code",  {30'd0, err_code}, 32'd2);
        chk("ovf_pc",    err_pc,            32'h2000_0020);
        chk("ovf_got",   err_got,           32'd104);
        chk("ovf_exp",   err_exp,           32'd0);

        // End of trace with empty buffer, then a stray commit.
        do_reset();
        idle(); gold_end = 1; step();
        chk("end_done", {31'd0, done}, 32'd1);
        idle(); lane1(32'h1c00_0020, 5'd3, 32'h33); step();
        chk("extra_error", {31'd0, error},    32'd1);
        chk("extra_code",  {30'd0, err_code}, 32'd3);
        chk("extra_done",  {31'd0, done},     32'd0);
        chk("extra_pc",    err_pc,            32'h1c00_0020);

        // Reset mid-operation discards buffered entries.
        do_reset();
        idle(); lane1(32'h3000_0000, 5'd9, 32'h99); step();
        do_reset();
        idle(); step();
        chk("midreset_ready", {31'd0, gold_ready}, 32'd0);

        // Randomized episodes.
        for (int ep = 0; ep < 20; ep++) begin
            do_reset();
            for (int c = 0; c < 80; c++) begin
                rnd_inputs();
                step();
            end
        end

        idle();
        step();
        @(negedge clk);
        @(negedge clk);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
